// File: rtl/mux_tree_scan_pkg.sv
// Shared types and elaboration-time helpers for the 4:1 mux tree with channel scan.
// Tree levels, tag width and flat node offsets are all derived from the channel count.
package mux_pkg;

   typedef enum logic {
      MODE_DIRECT = 1'b0,
      MODE_SCAN   = 1'b1
   } mode_e;

   localparam int FANIN   = 4;
   localparam int MIN_CH  = 2;
   localparam int MAX_CH  = 64;

   // Number of 4:1 levels needed to cover n leaves: ceil(log4(n)).
   function automatic int clog4(input int n);
      int levels;
      int span;
      levels = 0;
      span   = 1;
      while (span < n) begin
         span   = span * FANIN;
         levels = levels + 1;
      end
      return levels;
   endfunction

   // Tag carries two select bits per level, so it can address every padded leaf.
   function automatic int tag_width(input int ch);
      return 2 * clog4(ch);
   endfunction

   // Index of the first node of level k in a flat array holding all levels,
   // level 0 being the 4**levels leaves and level 'levels' the single root.
   function automatic int node_base(input int levels, input int k);
      int base;
      base = 0;
      for (int j = 0; j < k; j++) begin
         base = base + (1 << (2 * (levels - j)));
      end
      return base;
   endfunction

endpackage

// File: rtl/mux_tree_scan_stage.sv
// One level of the mux tree: N_IN/4 parallel 4:1 muxes steered by the tag bits for
// this level, with an optional register on data, tag, valid and wrap.
module mux4_stage
   import mux_pkg::*;
#(
   parameter int WIDTH = 1,
   parameter int N_IN  = 4,
   parameter int PIPE  = 1,
   parameter int TW    = 2,
   parameter int LVL   = 0
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [N_IN*WIDTH-1:0]           d_data,
   input  logic [TW-1:0]                   d_tag,
   input  logic                            d_valid,
   input  logic                            d_wrap,
   output logic [(N_IN/FANIN)*WIDTH-1:0]   q_data,
   output logic [TW-1:0]                   q_tag,
   output logic                            q_valid,
   output logic                            q_wrap
);

   localparam int N_OUT = N_IN / FANIN;

   logic [1:0]             pick;
   logic [N_OUT*WIDTH-1:0] mux_data;

   // The tag travelling with this sample steers the level, never the live select.
   assign pick = d_tag[2*LVL +: 2];

   always_comb begin
      // NOTE: the default assignment ahead of the loop keeps this block latch-free.
      mux_data = '0;
      for (int j = 0; j < N_OUT; j++) begin
         mux_data[j*WIDTH +: WIDTH] = d_data[(FANIN*j + int'(pick))*WIDTH +: WIDTH];
      end
   end

   if (PIPE != 0) begin : g_reg
      always_ff @(posedge clk) begin
         // NOTE: sequential state uses non-blocking assignments only.
         if (rst) begin
            // NOTE: data registers are cleared as well, so nothing stale leaks out after reset.
            q_data  <= '0;
            q_tag   <= '0;
            q_valid <= 1'b0;
            q_wrap  <= 1'b0;
         end else begin
            q_data  <= mux_data;
            q_tag   <= d_tag;
            q_valid <= d_valid;
            q_wrap  <= d_wrap;
         end
      end
   end else begin : g_comb
      assign q_data  = mux_data;
      assign q_tag   = d_tag;
      assign q_valid = d_valid;
      assign q_wrap  = d_wrap;
   end

endmodule

// File: rtl/mux_tree_scan.sv
// CH-channel WIDTH-bit multiplexer built from 4:1 levels, with direct select or an
// internal channel scan; channel tag, valid and scan-wrap travel alongside the data.
module mux_tree_scan
   import mux_pkg::*;
#(
   parameter int   WIDTH     = 1,
   parameter int   CH        = 16,
   parameter int   PIPE      = 1,
   parameter int   DWELL     = 4,
   parameter int   MSB_FIRST = 0,
   localparam int  SW        = $clog2(CH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [CH*WIDTH-1:0]   d,
   input  logic [SW-1:0]         sel,
   input  logic                  mode,
   input  logic                  in_valid,
   output logic [WIDTH-1:0]      out_data,
   output logic [SW-1:0]         out_ch,
   output logic                  out_valid,
   output logic                  scan_wrap
);

   localparam int L     = clog4(CH);
   localparam int TW    = tag_width(CH);
   localparam int NLEAF = 1 << TW;
   localparam int NODES = node_base(L, L + 1);
   localparam int ROOT  = node_base(L, L);
   localparam int DW    = (DWELL > 1) ? $clog2(DWELL) : 1;

   logic [SW-1:0] ch_cnt;
   logic [DW-1:0] dwell_cnt;
   logic          scan_mode;
   logic          last_dwell;
   logic          last_ch;
   logic [SW-1:0] issue_ch;
   logic          issue_wrap;

   assign scan_mode  = (mode_e'(mode) == MODE_SCAN);
   assign last_dwell = (dwell_cnt == DW'(DWELL - 1));
   assign last_ch    = (ch_cnt == SW'(CH - 1));
   assign issue_wrap = scan_mode && in_valid && last_ch && last_dwell;

   always_comb begin
      issue_ch = sel;
      if (scan_mode) begin
         issue_ch = ch_cnt;
      end else if (MSB_FIRST != 0) begin
         // Legacy ordering; an out-of-range select lands on a zero leaf either way.
         issue_ch = SW'(CH - 1) - sel;
      end
   end

   // Direct mode parks the scan at channel 0 so a later switch to scan starts fresh.
   always_ff @(posedge clk) begin
      if (rst || !scan_mode) begin
         ch_cnt    <= '0;
         dwell_cnt <= '0;
      end else if (in_valid) begin
         if (last_dwell) begin
            dwell_cnt <= '0;
            ch_cnt    <= last_ch ? '0 : ch_cnt + SW'(1);
         end else begin
            dwell_cnt <= dwell_cnt + DW'(1);
         end
      end
   end

   // All tree levels share one flat node array; level 0 holds the padded leaves.
   logic [NODES*WIDTH-1:0] node_data;
   logic [TW-1:0]          lvl_tag [0:L];
   logic [L:0]             lvl_valid;
   logic [L:0]             lvl_wrap;

   assign node_data[CH*WIDTH-1:0] = d;
   if (NLEAF > CH) begin : g_pad
      assign node_data[NLEAF*WIDTH-1:CH*WIDTH] = '0;
   end

   assign lvl_tag[0]   = TW'(issue_ch);
   assign lvl_valid[0] = in_valid;
   assign lvl_wrap[0]  = issue_wrap;

   for (genvar i = 0; i < L; i++) begin : g_lvl
      localparam int NI = 1 << (2 * (L - i));
      localparam int IB = node_base(L, i);
      localparam int OB = node_base(L, i + 1);

      mux4_stage #(
         .WIDTH (WIDTH),
         .N_IN  (NI),
         .PIPE  (PIPE),
         .TW    (TW),
         .LVL   (i)
      ) u_stage (
         .clk     (clk),
         .rst     (rst),
         .d_data  (node_data[IB*WIDTH +: NI*WIDTH]),
         .d_tag   (lvl_tag[i]),
         .d_valid (lvl_valid[i]),
         .d_wrap  (lvl_wrap[i]),
         .q_data  (node_data[OB*WIDTH +: (NI/FANIN)*WIDTH]),
         .q_tag   (lvl_tag[i+1]),
         .q_valid (lvl_valid[i+1]),
         .q_wrap  (lvl_wrap[i+1])
      );
   end

   // Tag bits above SW only exist to steer padded levels.
   logic unused_tag_bits;
   assign unused_tag_bits = ^lvl_tag[L];

   if (PIPE != 0) begin : g_out_piped
      assign out_data  = node_data[ROOT*WIDTH +: WIDTH];
      assign out_ch    = lvl_tag[L][SW-1:0];
      assign out_valid = lvl_valid[L];
      assign scan_wrap = lvl_wrap[L];
   end else begin : g_out_reg
      always_ff @(posedge clk) begin
         if (rst) begin
            out_data  <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            scan_wrap <= 1'b0;
         end else begin
            out_data  <= node_data[ROOT*WIDTH +: WIDTH];
            out_ch    <= lvl_tag[L][SW-1:0];
            out_valid <= lvl_valid[L];
            scan_wrap <= lvl_wrap[L];
         end
      end
   end

endmodule

// File: tb/tb_mux_tree_scan.sv
// Directed bench for mux_tree_scan: four configurations driven from one linear sequence,
// inputs changed and outputs sampled 1 time unit after each rising edge.
module tb_mux_tree_scan;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // A: CH=16, WIDTH=8, PIPE=1, DWELL=4
   logic [127:0] a_d;
   logic [3:0]   a_sel;
   logic         a_mode, a_valid;
   logic [7:0]   a_out_data;
   logic [3:0]   a_out_ch;
   logic         a_out_valid, a_wrap;

   // B: CH=16, WIDTH=1, MSB_FIRST=1
   logic [15:0]  b_d;
   logic [3:0]   b_sel;
   logic         b_mode, b_valid;
   logic [0:0]   b_out_data;
   logic [3:0]   b_out_ch;
   logic         b_out_valid, b_wrap;

   // C: CH=4, WIDTH=8, PIPE=1, DWELL=2
   logic [31:0]  c_d;
   logic [1:0]   c_sel;
   logic         c_mode, c_valid;
   logic [7:0]   c_out_data;
   logic [1:0]   c_out_ch;
   logic         c_out_valid, c_wrap;

   // E: CH=6, WIDTH=8, PIPE=0
   logic [47:0]  e_d;
   logic [2:0]   e_sel;
   logic         e_mode, e_valid;
   logic [7:0]   e_out_data;
   logic [2:0]   e_out_ch;
   logic         e_out_valid, e_wrap;

   mux_tree_scan #(.WIDTH(8), .CH(16), .PIPE(1), .DWELL(4), .MSB_FIRST(0)) u_a (
      .clk(clk), .rst(rst), .d(a_d), .sel(a_sel), .mode(a_mode), .in_valid(a_valid),
      .out_data(a_out_data), .out_ch(a_out_ch), .out_valid(a_out_valid), .scan_wrap(a_wrap));

   mux_tree_scan #(.WIDTH(1), .CH(16), .PIPE(1), .DWELL(4), .MSB_FIRST(1)) u_b (
      .clk(clk), .rst(rst), .d(b_d), .sel(b_sel), .mode(b_mode), .in_valid(b_valid),
      .out_data(b_out_data), .out_ch(b_out_ch), .out_valid(b_out_valid), .scan_wrap(b_wrap));

   mux_tree_scan #(.WIDTH(8), .CH(4), .PIPE(1), .DWELL(2), .MSB_FIRST(0)) u_c (
      .clk(clk), .rst(rst), .d(c_d), .sel(c_sel), .mode(c_mode), .in_valid(c_valid),
      .out_data(c_out_data), .out_ch(c_out_ch), .out_valid(c_out_valid), .scan_wrap(c_wrap));

   mux_tree_scan #(.WIDTH(8), .CH(6), .PIPE(0), .DWELL(4), .MSB_FIRST(0)) u_e (
      .clk(clk), .rst(rst), .d(e_d), .sel(e_sel), .mode(e_mode), .in_valid(e_valid),
      .out_data(e_out_data), .out_ch(e_out_ch), .out_valid(e_out_valid), .scan_wrap(e_wrap));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   int scan_exp  [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
   int scan_exp2 [4] = '{0, 1, 1, 2};

   initial begin
      rst = 1'b1;
      for (int k = 0; k < 16; k++) a_d[k*8 +: 8] = 8'h10 + 8'(k);
      for (int k = 0; k < 4; k++)  c_d[k*8 +: 8] = 8'hA0 + 8'(k);
      for (int k = 0; k < 6; k++)  e_d[k*8 +: 8] = 8'hF0 + 8'(k);
      b_d = 16'h8000;
      a_sel = '0; b_sel = '0; c_sel = '0; e_sel = '0;
      a_mode = 1'b0; b_mode = 1'b0; c_mode = 1'b0; e_mode = 1'b0;
      a_valid = 1'b1; b_valid = 1'b1; c_valid = 1'b1; e_valid = 1'b1;

      // Reset held for three cycles with in_valid high
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("rst_valid[%0d]", i), a_out_valid, 0);
         check($sformatf("rst_data[%0d]", i), a_out_data, 0);
         check($sformatf("rst_wrap[%0d]", i), a_wrap, 0);
         check($sformatf("rst_e_valid[%0d]", i), e_out_valid, 0);
      end
      rst = 1'b0;
      a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0; e_valid = 1'b0;
      tick();
      check("post_rst_valid", a_out_valid, 0);

      // Direct mode, back-to-back channels 0..15, two-level latency
      for (int k = 0; k < 18; k++) begin
         a_valid = (k < 16);
         a_sel   = 4'(k);
         tick();
         if (k == 0 || k == 17) begin
            check($sformatf("dir_bubble[%0d]", k), a_out_valid, 0);
         end else begin
            check($sformatf("dir_valid[%0d]", k - 1), a_out_valid, 1);
            check($sformatf("dir_data[%0d]", k - 1), a_out_data, 32'h10 + 32'(k - 1));
            check($sformatf("dir_ch[%0d]", k - 1), a_out_ch, 32'(k - 1));
         end
      end
      a_valid = 1'b0;

      // MSB_FIRST mapping
      b_valid = 1'b1;
      b_sel   = 4'd0;
      tick();
      b_sel   = 4'd1;
      tick();
      check("msb_s0_valid", b_out_valid, 1);
      check("msb_s0_data", b_out_data, 1);
      check("msb_s0_ch", b_out_ch, 15);
      b_valid = 1'b0;
      tick();
      check("msb_s1_valid", b_out_valid, 1);
      check("msb_s1_data", b_out_data, 0);
      check("msb_s1_ch", b_out_ch, 14);
      tick();
      check("msb_tail_valid", b_out_valid, 0);

      // Scan, CH=4, DWELL=2, continuous in_valid
      c_mode  = 1'b1;
      c_valid = 1'b1;
      for (int i = 0; i < 9; i++) begin
         tick();
         check($sformatf("scan_valid[%0d]", i), c_out_valid, 1);
         check($sformatf("scan_ch[%0d]", i), c_out_ch, 32'(scan_exp[i]));
         check($sformatf("scan_data[%0d]", i), c_out_data, 32'hA0 + 32'(scan_exp[i]));
         check($sformatf("scan_wrap[%0d]", i), c_wrap, (i == 7) ? 1 : 0);
      end
      // Gap of three idle cycles in the middle of channel 0's dwell
      c_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("scan_gap_valid[%0d]", i), c_out_valid, 0);
         check($sformatf("scan_gap_wrap[%0d]", i), c_wrap, 0);
      end
      c_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("scan_resume_ch[%0d]", i), c_out_ch, 32'(scan_exp2[i]));
         check($sformatf("scan_resume_valid[%0d]", i), c_out_valid, 1);
         check($sformatf("scan_resume_wrap[%0d]", i), c_wrap, 0);
      end
      // Dropping to direct mode and back restarts the scan at channel 0
      c_mode  = 1'b0;
      c_valid = 1'b0;
      tick();
      c_mode  = 1'b1;
      c_valid = 1'b1;
      tick();
      check("scan_restart_ch", c_out_ch, 0);
      check("scan_restart_valid", c_out_valid, 1);
      c_valid = 1'b0;
      c_mode  = 1'b0;

      // CH=6, PIPE=0: out-of-range select reads zero one cycle later
      check("oor_idle_valid", e_out_valid, 0);
      e_valid = 1'b1;
      e_sel   = 3'd7;
      tick();
      check("oor_valid", e_out_valid, 1);
      check("oor_data", e_out_data, 0);
      check("oor_ch", e_out_ch, 7);
      e_sel = 3'd5;
      tick();
      check("ch5_valid", e_out_valid, 1);
      check("ch5_data", e_out_data, 32'hF5);
      check("ch5_ch", e_out_ch, 5);
      e_valid = 1'b0;
      tick();
      check("e_tail_valid", e_out_valid, 0);

      // Reset with samples in flight, scan already past channel 0
      a_mode  = 1'b1;
      a_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (i == 0) begin
            check("inflight_first_valid", a_out_valid, 0);
         end else begin
            check($sformatf("inflight_ch[%0d]", i - 1), a_out_ch, (i - 1 < 4) ? 0 : 1);
            check($sformatf("inflight_valid[%0d]", i - 1), a_out_valid, 1);
         end
      end
      rst = 1'b1;
      tick();
      check("midrst_valid0", a_out_valid, 0);
      tick();
      check("midrst_valid1", a_out_valid, 0);
      rst = 1'b0;
      tick();
      check("postrst_valid0", a_out_valid, 0);
      tick();
      check("postrst_valid1", a_out_valid, 1);
      check("postrst_ch", a_out_ch, 0);
      check("postrst_data", a_out_data, 32'h10);
      a_valid = 1'b0;
      a_mode  = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
